// File: rtl/cpu8_pkg.sv
// cpu8_pkg: shared CPU8 memory constants and the loader state encoding (CHK exists only with CHECKSUM_EN).
package cpu8_pkg;
  localparam int ADDR_W = 8;
  localparam int WORD_W = 18;
  localparam int DEPTH = 64;
  localparam int BYTES_PER_WORD = 3;
  typedef enum logic [3:0] {
    IDLE, HDR, B0, B1, B2, WRITE,
`ifdef CHECKSUM_EN
    CHK,
`endif
    FIN, ERR
  } loader_state_t;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input handshake plus the instruction-memory write port.
interface program_loader_if;
  logic in_valid;
  logic in_ready;
  logic [7:0] in_data;
  logic mem_we;
  logic [cpu8_pkg::ADDR_W-1:0] mem_addr;
  logic [cpu8_pkg::WORD_W-1:0] mem_wdata;
  modport master(input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
  modport slave(output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/byte_word_packer.sv
// byte_word_packer: assembles three big-endian bytes into one instruction word and flags a nonzero b0 pad.
module byte_word_packer
  import cpu8_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic [7:0] data,
  output logic [WORD_W-1:0] word,
  output logic word_valid,
  output logic pad_err
);
  localparam int HI_W = WORD_W - 8;
  logic [1:0] idx_q, idx_d;
  logic [HI_W-1:0] hi_q, hi_d;
  logic last;
  assign last = idx_q == 2'(BYTES_PER_WORD - 1);
  always_comb begin
    idx_d = clear || (load && last) ? 2'd0 : load ? idx_q + 2'd1 : idx_q;
    hi_d = !load ? hi_q : idx_q == 2'd0 ? {data[HI_W-9:0], 8'h00} : idx_q == 2'd1 ? {hi_q[HI_W-1:8], data} : hi_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      idx_q <= '0;
      hi_q <= '0;
    end else begin
      idx_q <= idx_d;
      hi_q <= hi_d;
    end
  // the third byte completes the word combinationally so it can be registered straight into mem_wdata
  assign word = {hi_q, data};
  assign word_valid = load && last;
  assign pad_err = load && idx_q == 2'd0 && |data[7:2];
endmodule

// File: rtl/program_loader.sv
// program_loader: frames a byte stream into 18-bit words and writes them to CPU8 memory while holding the CPU.
// Define CHECKSUM_EN to require a trailing mod-256 sum byte after the last word.
module program_loader
  import cpu8_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  program_loader_if.master bus,
  output logic busy,
  output logic done,
  output logic err,
  output logic cpu_hold
);
`ifdef CHECKSUM_EN
  localparam loader_state_t AFTER_LAST = CHK;
`else
  localparam loader_state_t AFTER_LAST = FIN;
`endif
  loader_state_t state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d, addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d, word;
  logic mem_we_q, mem_we_d, busy_q, busy_d, done_q, done_d, err_q, err_d, hold_q, hold_d;
  logic in_word, in_ready, xfer, word_valid, pad_err;
`ifdef CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif
  assign in_word = state_q inside {B0, B1, B2};
`ifdef CHECKSUM_EN
  assign in_ready = in_word || state_q inside {HDR, CHK};
`else
  assign in_ready = in_word || state_q == HDR;
`endif
  assign xfer = bus.in_valid && in_ready;
  byte_word_packer u_packer (
    .clk(clk),
    .rst(rst),
    .clear(!in_word),
    .load(xfer && in_word),
    .data(bus.in_data),
    .word(word),
    .word_valid(word_valid),
    .pad_err(pad_err)
  );
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    addr_d = addr_q;
    mem_we_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d = err_q;
    hold_d = hold_q;
`ifdef CHECKSUM_EN
    sum_d = state_q == IDLE ? 8'h00 : xfer && state_q != CHK ? sum_q + bus.in_data : sum_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = HDR;
        busy_d = 1'b1;
        hold_d = 1'b1;
        done_d = 1'b0;
        err_d = 1'b0;
      end
      HDR: if (xfer) begin
        state_d = bus.in_data == 8'h00 || int'(bus.in_data) > DEPTH ? ERR : B0;
        n_d = ADDR_W'(bus.in_data);
        addr_d = '0;
      end
      B0: if (xfer) state_d = pad_err ? ERR : B1;
      B1: if (xfer) state_d = B2;
      B2: if (word_valid) begin
        state_d = WRITE;
        mem_we_d = 1'b1;
        mem_addr_d = addr_q;
        mem_wdata_d = word;
      end
      WRITE: begin
        addr_d = addr_q + 1'b1;
        state_d = addr_q == n_q - 1'b1 ? AFTER_LAST : B0;
      end
`ifdef CHECKSUM_EN
      CHK: if (xfer) state_d = bus.in_data == sum_q ? FIN : ERR;
`endif
      FIN: begin
        state_d = IDLE;
        busy_d = 1'b0;
        hold_d = 1'b0;
        done_d = 1'b1;
      end
      ERR: begin
        state_d = IDLE;
        busy_d = 1'b0;
        err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      addr_q <= '0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      hold_q <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      addr_q <= addr_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      hold_q <= hold_d;
`ifdef CHECKSUM_EN
      sum_q <= sum_d;
`endif
    end
  assign bus.in_ready = in_ready;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign cpu_hold = hold_q;
endmodule
